// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD tape renderer: character codes, tape
// symbol codes, message identifiers, controller states and the symbol
// to character mapping used when drawing tape cells.
package lcd_pkg;

    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_ZERO  = 8'h30;
    localparam logic [7:0] ASC_ONE   = 8'h31;
    localparam logic [7:0] ASC_HASH  = 8'h23;
    localparam logic [7:0] ASC_CARET = 8'h5E;
    localparam logic [7:0] ASC_QMARK = 8'h3F;

    // Stored message texts are this many characters wide before fitting
    localparam int MSG_CHARS = 16;

    typedef enum logic [1:0] {
        SYM_BLANK = 2'd0,
        SYM_ZERO  = 2'd1,
        SYM_ONE   = 2'd2,
        SYM_HASH  = 2'd3
    } sym_e;

    typedef enum logic [3:0] {
        MSG_PRESENT_CHOICE = 4'd0,
        MSG_GET_STATE      = 4'd1,
        MSG_GET_READ       = 4'd2,
        MSG_GET_WRITE      = 4'd3
    } msg_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MSG    = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SHIFT  = 3'd4,
        ST_COMMIT = 3'd5,
        ST_HOLD   = 3'd6
    } state_e;

    // Tape symbol to display character; unknown codes show as '?'
    function automatic logic [7:0] sym_to_ascii(input logic [31:0] code);
        logic [7:0] ch;
        if (code == 32'(SYM_BLANK))
            ch = ASC_SPACE;
        else if (code == 32'(SYM_ZERO))
            ch = ASC_ZERO;
        else if (code == 32'(SYM_ONE))
            ch = ASC_ONE;
        else if (code == 32'(SYM_HASH))
            ch = ASC_HASH;
        else
            ch = ASC_QMARK;
        return ch;
    endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Fixed prompt texts for the LCD. Purely combinational: a message id
// selects two lines, each stored as 16 characters and then padded with
// spaces or truncated to the configured line width. Unknown ids give
// blank lines.
module lcd_msg_rom
    import lcd_pkg::*;
#(
    parameter int COLS = 16
) (
    input  logic [3:0]          msg_id,
    output logic [8*COLS-1:0]   line1,
    output logic [8*COLS-1:0]   line2
);

    localparam logic [8*MSG_CHARS-1:0] TXT_BLANK   = "                ";
    localparam logic [8*MSG_CHARS-1:0] TXT_PC_1    = "Edit Tape: 0    ";
    localparam logic [8*MSG_CHARS-1:0] TXT_PC_2    = "Edit States: 1  ";
    localparam logic [8*MSG_CHARS-1:0] TXT_GS_1    = "State number?   ";
    localparam logic [8*MSG_CHARS-1:0] TXT_GS_2    = "Head at caret   ";
    localparam logic [8*MSG_CHARS-1:0] TXT_GR_1    = "Read symbol?    ";
    localparam logic [8*MSG_CHARS-1:0] TXT_GW_1    = "Write symbol?   ";
    localparam logic [8*MSG_CHARS-1:0] TXT_SYMKEY  = "0=_ 1=0 2=1 3=# ";

    // Fit a stored 16-character text into a COLS-character line
    function automatic logic [8*COLS-1:0] fit_line(input logic [8*MSG_CHARS-1:0] text);
        logic [8*COLS-1:0] res;
        int src;
        res = '0;
        for (int c = 0; c < COLS; c++) begin
            src = (c < MSG_CHARS) ? (MSG_CHARS - 1 - c) : 0;
            if (c < MSG_CHARS)
                res[8*(COLS-1-c) +: 8] = text[8*src +: 8];
            else
                res[8*(COLS-1-c) +: 8] = ASC_SPACE;
        end
        return res;
    endfunction

    logic [8*MSG_CHARS-1:0] text1;
    logic [8*MSG_CHARS-1:0] text2;

    // Select the raw texts for the requested message
    always_comb begin
        text1 = TXT_BLANK;
        text2 = TXT_BLANK;
        case (msg_id)
            MSG_PRESENT_CHOICE: begin
                text1 = TXT_PC_1;
                text2 = TXT_PC_2;
            end
            MSG_GET_STATE: begin
                text1 = TXT_GS_1;
                text2 = TXT_GS_2;
            end
            MSG_GET_READ: begin
                text1 = TXT_GR_1;
                text2 = TXT_SYMKEY;
            end
            MSG_GET_WRITE: begin
                text1 = TXT_GW_1;
                text2 = TXT_SYMKEY;
            end
            default: begin
                text1 = TXT_BLANK;
                text2 = TXT_BLANK;
            end
        endcase
    end

    assign line1 = fit_line(text1);
    assign line2 = fit_line(text2);

endmodule

// File: rtl/lcd_tape_renderer.sv
// Renders either a window of Turing tape centred on the head, or a
// fixed prompt, into two LCD text lines. Tape cells are read one at a
// time over a req/ack port with a timeout; characters are shifted into
// shadow lines and only copied to the visible lines once the frame is
// complete, so the display never shows a half-drawn frame.
module lcd_tape_renderer
    import lcd_pkg::*;
#(
    parameter int COLS     = 16,
    parameter int ADDR_W   = 10,
    parameter int SYM_W    = 2,
    parameter int HEAD_COL = 8,
    parameter int TIMEOUT  = 15,
    parameter int NUM_MSG  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [3:0]          msg_id,
    input  logic [ADDR_W-1:0]   head_loc,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [SYM_W-1:0]    mem_data,
    output logic [8*COLS-1:0]   line1,
    output logic [8*COLS-1:0]   line2
);

    localparam int LINE_W  = 8 * COLS;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [LINE_W-1:0] BLANK_LINE = {COLS{ASC_SPACE}};

    state_e                 state;
    state_e                 next_state;

    logic                   mode_q;
    logic [3:0]             msg_id_q;
    logic [ADDR_W-1:0]      base;
    logic [COL_W-1:0]       col;
    logic [TIMER_W-1:0]     timer;
    logic [7:0]             cell_char;
    logic [LINE_W-1:0]      shadow1;
    logic [LINE_W-1:0]      shadow2;
    logic [LINE_W-1:0]      rom_line1;
    logic [LINE_W-1:0]      rom_line2;

    logic                   timed_out;
    logic                   last_col;
    logic                   at_head;
    logic                   msg_bad;
    logic [ADDR_W-1:0]      fetch_addr;

    assign timed_out  = (timer == TIMER_W'(TIMEOUT - 1));
    assign last_col   = (col == COL_W'(COLS - 1));
    assign at_head    = (col == COL_W'(HEAD_COL));
    assign msg_bad    = (32'(msg_id_q) >= 32'(NUM_MSG));
    assign fetch_addr = base + ADDR_W'(col);

    lcd_msg_rom #(
        .COLS   (COLS)
    ) u_msg_rom (
        .msg_id (msg_id_q),
        .line1  (rom_line1),
        .line2  (rom_line2)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; an ack in the timeout cycle still counts as a read
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    next_state = mode ? ST_MSG : ST_FETCH;
            end
            ST_MSG:    next_state = ST_COMMIT;
            ST_FETCH:  next_state = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack || timed_out)
                    next_state = ST_SHIFT;
            end
            ST_SHIFT:  next_state = last_col ? ST_COMMIT : ST_FETCH;
            ST_COMMIT: next_state = ST_HOLD;
            ST_HOLD: begin
                if (!start)
                    next_state = ST_IDLE;
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    // Datapath: request latching, memory port, shadow lines and commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= 1'b0;
            msg_id_q  <= '0;
            base      <= '0;
            col       <= '0;
            timer     <= '0;
            cell_char <= '0;
            shadow1   <= '0;
            shadow2   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            line1     <= BLANK_LINE;
            line2     <= BLANK_LINE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        msg_id_q <= msg_id;
                        base     <= head_loc - ADDR_W'(HEAD_COL);
                        col      <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_MSG: begin
                    if (msg_bad) begin
                        shadow1 <= BLANK_LINE;
                        shadow2 <= BLANK_LINE;
                        err     <= 1'b1;
                    end else begin
                        shadow1 <= rom_line1;
                        shadow2 <= rom_line2;
                    end
                end
                ST_FETCH: begin
                    mem_req  <= 1'b1;
                    mem_addr <= fetch_addr;
                    timer    <= '0;
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        cell_char <= sym_to_ascii(32'(mem_data));
                        mem_req   <= 1'b0;
                    end else if (timed_out) begin
                        cell_char <= ASC_QMARK;
                        mem_req   <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    shadow1 <= {shadow1[LINE_W-9:0], cell_char};
                    shadow2 <= {shadow2[LINE_W-9:0], (at_head ? ASC_CARET : ASC_SPACE)};
                    if (!last_col)
                        col <= col + 1'b1;
                end
                ST_COMMIT: begin
                    line1 <= shadow1;
                    line2 <= shadow2;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_HOLD: begin
                    if (!start)
                        done <= 1'b0;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_tape_renderer.sv
// Directed bench for lcd_tape_renderer: message renders, tape windows
// with wrap-around, a stalled memory read, start hold-off and reset in
// the middle of a render.
module tb_lcd_tape_renderer;

    localparam int COLS   = 16;
    localparam int ADDR_W = 10;
    localparam logic [127:0] SPACES = {16{8'h20}};

    logic               clk;
    logic               rst;
    logic               start;
    logic               mode;
    logic [3:0]         msg_id;
    logic [ADDR_W-1:0]  head_loc;
    logic               busy;
    logic               done;
    logic               err;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [1:0]         mem_data;
    logic [8*COLS-1:0]  line1;
    logic [8*COLS-1:0]  line2;

    logic [1:0]         mem [0:1023];
    logic               stall_en;
    logic [ADDR_W-1:0]  stall_addr;

    logic [ADDR_W-1:0]  addr_log [0:255];
    int                 n_addr;
    int                 stall_hi;
    logic               req_prev;

    int                 checks;
    int                 errors;

    lcd_tape_renderer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .msg_id   (msg_id),
        .head_loc (head_loc),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .line1    (line1),
        .line2    (line2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency memory: acks in the same cycle as the request unless stalled
    assign mem_ack  = mem_req && !(stall_en && (mem_addr == stall_addr));
    assign mem_data = mem[mem_addr];

    // Log every new request address and time the stalled request
    always @(posedge clk) begin
        req_prev <= mem_req;
        if (mem_req && !req_prev && n_addr < 256) begin
            addr_log[n_addr] <= mem_addr;
            n_addr <= n_addr + 1;
        end
        if (mem_req && stall_en && mem_addr == stall_addr)
            stall_hi <= stall_hi + 1;
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise start with the given request and count edges until done
    task automatic apply_stimulus(input logic m, input logic [3:0] id,
                                  input logic [ADDR_W-1:0] head, output int cycles);
        @(negedge clk);
        mode     = m;
        msg_id   = id;
        head_loc = head;
        start    = 1'b1;
        cycles   = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
        check_output("render_done", 128'(done), 128'(1'b1));
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int base_idx;
        logic [127:0] exp1;
        logic [127:0] caret_line;

        checks     = 0;
        errors     = 0;
        n_addr     = 0;
        stall_hi   = 0;
        req_prev   = 1'b0;
        rst        = 1'b0;
        start      = 1'b0;
        mode       = 1'b0;
        msg_id     = 4'd0;
        head_loc   = '0;
        stall_en   = 1'b0;
        stall_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 2'd0;
        mem[10'h100] = 2'd2;

        caret_line = SPACES;
        caret_line[8*(15-8) +: 8] = 8'h5E;

        #12;
        check_output("reset_busy", 128'(busy), 128'(1'b0));
        check_output("reset_done", 128'(done), 128'(1'b0));
        check_output("reset_err", 128'(err), 128'(1'b0));
        check_output("reset_req", 128'(mem_req), 128'(1'b0));
        check_output("reset_addr", 128'(mem_addr), 128'(0));
        check_output("reset_line1", line1, SPACES);
        check_output("reset_line2", line2, SPACES);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] message 0");
        apply_stimulus(1'b1, 4'd0, '0, cyc);
        check_output("msg0_latency", 128'(cyc), 128'(3));
        check_output("msg0_line1", line1, "Edit Tape: 0    ");
        check_output("msg0_line2", line2, "Edit States: 1  ");
        check_output("msg0_err", 128'(err), 128'(1'b0));
        check_output("msg0_busy", 128'(busy), 128'(1'b0));
        release_start();

        $display("[TB] bad message id");
        apply_stimulus(1'b1, 4'd9, '0, cyc);
        check_output("msg9_latency", 128'(cyc), 128'(3));
        check_output("msg9_line1", line1, SPACES);
        check_output("msg9_line2", line2, SPACES);
        check_output("msg9_err", 128'(err), 128'(1'b1));
        release_start();

        $display("[TB] tape window at 0x100");
        base_idx = n_addr;
        apply_stimulus(1'b0, 4'd0, 10'h100, cyc);
        exp1 = SPACES;
        exp1[8*(15-8) +: 8] = 8'h31;
        check_output("tape_latency", 128'(cyc), 128'(50));
        check_output("tape_nreq", 128'(n_addr - base_idx), 128'(16));
        for (int i = 0; i < 16; i++)
            check_output($sformatf("tape_addr%0d", i), 128'(addr_log[base_idx + i]), 128'(10'h0F8 + i));
        check_output("tape_line1", line1, exp1);
        check_output("tape_line2", line2, caret_line);
        check_output("tape_err", 128'(err), 128'(1'b0));
        release_start();

        $display("[TB] tape window wrapping below zero");
        base_idx = n_addr;
        apply_stimulus(1'b0, 4'd0, 10'd3, cyc);
        check_output("wrap_first_addr", 128'(addr_log[base_idx]), 128'(10'h3FB));
        check_output("wrap_col5_addr", 128'(addr_log[base_idx + 5]), 128'(10'h000));
        check_output("wrap_last_addr", 128'(addr_log[base_idx + 15]), 128'(10'h00A));
        check_output("wrap_line1", line1, SPACES);
        check_output("wrap_line2", line2, caret_line);
        check_output("wrap_err", 128'(err), 128'(1'b0));
        release_start();

        $display("[TB] stalled read at 0x105");
        stall_en   = 1'b1;
        stall_addr = 10'h105;
        base_idx   = n_addr;
        apply_stimulus(1'b0, 4'd0, 10'h100, cyc);
        exp1 = SPACES;
        exp1[8*(15-8) +: 8]  = 8'h31;
        exp1[8*(15-13) +: 8] = 8'h3F;
        check_output("stall_latency", 128'(cyc), 128'(64));
        check_output("stall_req_cycles", 128'(stall_hi), 128'(15));
        check_output("stall_line1", line1, exp1);
        check_output("stall_line2", line2, caret_line);
        check_output("stall_err", 128'(err), 128'(1'b1));
        stall_en = 1'b0;

        $display("[TB] start held after done");
        base_idx = n_addr;
        repeat (10) @(posedge clk);
        #1;
        check_output("hold_done", 128'(done), 128'(1'b1));
        check_output("hold_busy", 128'(busy), 128'(1'b0));
        check_output("hold_no_req", 128'(n_addr - base_idx), 128'(0));
        release_start();
        check_output("release_done", 128'(done), 128'(1'b0));
        check_output("release_line1", line1, exp1);

        $display("[TB] reset during render");
        @(negedge clk);
        mode     = 1'b0;
        head_loc = 10'h100;
        start    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("prereset_req", 128'(mem_req), 128'(1'b1));
        rst = 1'b0;
        #1;
        check_output("midreset_req", 128'(mem_req), 128'(1'b0));
        check_output("midreset_done", 128'(done), 128'(1'b0));
        check_output("midreset_busy", 128'(busy), 128'(1'b0));
        check_output("midreset_line1", line1, SPACES);
        check_output("midreset_line2", line2, SPACES);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
